// File: rtl/scoreboard_regfile.sv
// ---------------------------------------------------------------------------
// scoreboard_regfile
//   Register file with a per-register count of in-flight writes. Issue is
//   held off while a source operand still has a pending producer, or while
//   the destination already has MAXOUT writes outstanding. Writebacks may
//   return with any latency and in any order; each one retires one count.
//
//   Optional feature macro: SCOREBOARD_BYPASS_EN
//     defined   : writeback data is forwarded to the read ports in the same
//                 cycle, and a source whose last pending write is arriving
//                 now is not considered busy.
//     undefined : reads always come from the stored registers; any pending
//                 write on a source stalls.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_rs_addr/i_rs_used   NRD source addresses (packed, AW each) + used mask
//   o_rs_data             NRD read results (packed, XLEN each), combinational
//   i_issue_vld/i_issue_rd  instruction issue request and destination
//   o_issue_ok/o_stall    issue accepted / issue held
//   i_wb_vld/i_wb_kill/i_wb_rd/i_wb_data  writeback of one in-flight result
//   o_wb_err              sticky flag for writebacks with nothing in flight
// ---------------------------------------------------------------------------
module scoreboard_regfile #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int MAXOUT = 3,
  localparam int AW     = $clog2(NREG),
  localparam int CW     = $clog2(MAXOUT + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  input  logic [NRD-1:0]      i_rs_used,
  output logic [NRD*XLEN-1:0] o_rs_data,
  input  logic                i_issue_vld,
  input  logic [AW-1:0]       i_issue_rd,
  output logic                o_issue_ok,
  output logic                o_stall,
  input  logic                i_wb_vld,
  input  logic                i_wb_kill,
  input  logic [AW-1:0]       i_wb_rd,
  input  logic [XLEN-1:0]     i_wb_data,
  output logic                o_wb_err
);

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [XLEN-1:0] r_regs [NREG];
  logic [CW-1:0]   r_cnt  [NREG];
  logic            r_wb_err;

  logic            w_wr_en;
  logic            w_full;
  logic            w_wb_bad;
  logic [NRD-1:0]  w_src_busy;
  logic [NREG-1:0] w_inc;
  logic [NREG-1:0] w_dec;

  assign w_wr_en = i_wb_vld && !i_wb_kill && (i_wb_rd != '0);

  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic [AW-1:0] w_a;
    logic          w_fwd;
    assign w_a   = i_rs_addr[g*AW +: AW];
    assign w_fwd = BYP && w_wr_en && (i_wb_rd == w_a);
    assign o_rs_data[g*XLEN +: XLEN] = (w_a == '0) ? '0 :
                                       w_fwd       ? i_wb_data : r_regs[w_a];
    // The last outstanding producer landing this cycle is forwarded, so the
    // consumer need not wait for it.
    assign w_src_busy[g] = i_rs_used[g] && (w_a != '0) && (r_cnt[w_a] != '0) &&
                           !(w_fwd && (r_cnt[w_a] == CW'(1)));
  end

  // A writeback to the same destination frees a slot this cycle, so a full
  // destination may still accept one more issue.
  assign w_full = (i_issue_rd != '0) && (r_cnt[i_issue_rd] == CW'(MAXOUT)) &&
                  !(i_wb_vld && (i_wb_rd == i_issue_rd));

  assign o_stall    = i_issue_vld && ((|w_src_busy) || w_full);
  assign o_issue_ok = i_issue_vld && !o_stall;
  assign w_wb_bad   = i_wb_vld && ((i_wb_rd == '0) || (r_cnt[i_wb_rd] == '0));
  assign o_wb_err   = r_wb_err;

  // Decrement only a nonzero count, so a stray writeback can never underflow.
  assign w_inc[0] = 1'b0;
  assign w_dec[0] = 1'b0;
  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    assign w_inc[r] = o_issue_ok && (i_issue_rd == AW'(r));
    assign w_dec[r] = i_wb_vld && (i_wb_rd == AW'(r)) && (r_cnt[r] != '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_wb_err <= 1'b0;
    end else begin
      if (w_wr_en)  r_regs[i_wb_rd] <= i_wb_data;
      if (w_wb_bad) r_wb_err <= 1'b1;
      for (int r = 1; r < NREG; r++) begin
        if (w_inc[r] && !w_dec[r])      r_cnt[r] <= r_cnt[r] + CW'(1);
        else if (w_dec[r] && !w_inc[r]) r_cnt[r] <= r_cnt[r] - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
module tb_scoreboard_regfile;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rs_addr;
  logic [1:0]  rs_used;
  logic [63:0] rs_data;
  logic        issue_vld, issue_ok, stall;
  logic [4:0]  issue_rd;
  logic        wb_vld, wb_kill, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  scoreboard_regfile dut (
    .i_clk(clk), .i_reset(reset), .i_rs_addr(rs_addr), .i_rs_used(rs_used),
    .o_rs_data(rs_data), .i_issue_vld(issue_vld), .i_issue_rd(issue_rd),
    .o_issue_ok(issue_ok), .o_stall(stall), .i_wb_vld(wb_vld),
    .i_wb_kill(wb_kill), .i_wb_rd(wb_rd), .i_wb_data(wb_data), .o_wb_err(wb_err)
  );

  typedef struct {
    logic        stall, ok, err;
    logic [31:0] d0, d1;
    string       tag;
  } exp_t;
  exp_t q[$];

  // Reference model: architectural values and a plain integer count of
  // outstanding writes per register.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic        m_err;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic wr,
                                         input logic [4:0] wrd, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (BYP && wr && wrd == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic used, input logic [4:0] a,
                                  input logic wr, input logic [4:0] wrd);
    if (!used || a == 0 || m_cnt[a] == 0) return 1'b0;
    if (BYP && m_cnt[a] == 1 && wr && wrd == a) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input string tag, input logic chk, input logic rst,
                       input logic [1:0] used, input logic [4:0] a0, input logic [4:0] a1,
                       input logic iv, input logic [4:0] ird,
                       input logic wv, input logic wk, input logic [4:0] wrd,
                       input logic [31:0] wd);
    exp_t e;
    logic wr, full;
    logic dec_ok;
    reset = rst; rs_used = used; rs_addr = {a1, a0};
    issue_vld = iv; issue_rd = ird;
    wb_vld = wv; wb_kill = wk; wb_rd = wrd; wb_data = wd;
    wr   = wv && !wk && wrd != 0;
    full = ird != 0 && m_cnt[ird] == 3 && !(wv && wrd == ird);
    e.tag   = tag;
    e.d0    = m_read(a0, wr, wrd, wd);
    e.d1    = m_read(a1, wr, wrd, wd);
    e.stall = iv && (m_busy(used[0], a0, wr, wrd) || m_busy(used[1], a1, wr, wrd) || full);
    e.ok    = iv && !e.stall;
    e.err   = m_err;
    if (chk) q.push_back(e);
    // state seen after the coming edge
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_cnt[r] = 0; end
      m_err = 0;
    end else begin
      dec_ok = wv && wrd != 0 && m_cnt[wrd] > 0;
      if (wv && !dec_ok) m_err = 1;
      if (wr) m_regs[wrd] = wd;
      if (e.ok && ird != 0) m_cnt[ird]++;
      if (dec_ok) m_cnt[wrd]--;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag, input logic [1:0] used, input logic [4:0] a0,
                      input logic [4:0] a1, input logic iv, input logic [4:0] ird);
    drive(tag, 1, 0, used, a0, a1, iv, ird, 0, 0, 0, 0);
  endtask

  task automatic cmp(input string tag, input string what, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, what, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.tag, "stall",    {31'b0, stall},    {31'b0, e.stall});
      cmp(e.tag, "issue_ok", {31'b0, issue_ok}, {31'b0, e.ok});
      cmp(e.tag, "wb_err",   {31'b0, wb_err},   {31'b0, e.err});
      cmp(e.tag, "rs_data0", rs_data[31:0],     e.d0);
      cmp(e.tag, "rs_data1", rs_data[63:32],    e.d1);
    end
  end

  initial begin
    logic [4:0] wrd;
    int start;
    for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_cnt[r] = 0; end
    m_err = 0;
    @(posedge clk); #1;
    drive("rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("rst2", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // 1: everything reads zero; write to x0 is illegal
    for (int r = 0; r < 32; r++) idle("t1_read", 2'b11, 5'(r), 5'(31 - r), 1, 0);
    drive("t1_x0wr", 1, 0, 2'b11, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    idle("t1_after", 2'b11, 0, 1, 1, 0);

    // 2: RAW on x5
    drive("t2_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("t2_iss5", 0, 0, 0, 1, 5);
    drive("t2_dep", 1, 0, 2'b01, 5, 0, 1, 0, 1, 0, 5, 32'h0000_1234);
    idle("t2_next", 2'b01, 5, 0, 1, 0);

    // 3: WAW limit on x7
    for (int k = 0; k < 3; k++) idle("t3_iss7", 0, 0, 0, 1, 7);
    idle("t3_full", 0, 0, 0, 1, 7);
    drive("t3_fullwb", 1, 0, 0, 0, 0, 1, 0, 1, 0, 7, 32'h77);
    idle("t3_still", 0, 0, 0, 1, 7);
    for (int k = 0; k < 3; k++) drive("t3_drain", 1, 0, 2'b01, 7, 0, 1, 0, 1, 0, 7, 32'h700 + k);
    idle("t3_clear", 2'b11, 7, 7, 1, 7);
    drive("t3_wb", 1, 0, 0, 0, 0, 0, 0, 1, 0, 7, 32'h7777);

    // 4: killed writeback on x9
    drive("t4_pre", 1, 0, 0, 0, 0, 0, 0, 1, 0, 9, 32'h0);
    idle("t4_iss9", 0, 0, 0, 1, 9);
    drive("t4_kill", 1, 0, 2'b10, 0, 9, 0, 0, 1, 1, 9, 32'hDEAD_BEEF);
    idle("t4_read", 2'b10, 0, 9, 1, 0);

    // 5: rs_used masks hazards
    drive("t5_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("t5_iss11", 0, 0, 0, 1, 11);
    idle("t5_unused", 2'b00, 11, 11, 1, 0);
    idle("t5_used1", 2'b10, 0, 11, 1, 0);
    drive("t5_wb", 1, 0, 0, 0, 0, 0, 0, 1, 0, 11, 32'hB);

    // 6: reset drops in-flight writes
    idle("t6_iss3", 0, 0, 0, 1, 3);
    drive("t6_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("t6_wb", 1, 0, 2'b01, 3, 0, 1, 3, 1, 0, 3, 32'h3333_0003);
    idle("t6_read", 2'b01, 3, 0, 1, 0);
    idle("t6_iss3b", 2'b01, 3, 0, 1, 3);

    // randomized traffic, biased to a few registers to create hazards
    drive("r_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic wv;
      wv = 0; wrd = 0;
      if ($urandom_range(1, 0) == 1) begin
        start = $urandom_range(31, 1);
        for (int k = 0; k < 31; k++) begin
          int r;
          r = 1 + (start - 1 + k) % 31;
          if (!wv && m_cnt[r] > 0) begin wv = 1; wrd = 5'(r); end
        end
      end
      drive("rand", 1, ($urandom_range(299, 0) == 0),
            2'($urandom), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
            1'($urandom), ($urandom_range(3, 0) == 0) ? 5'($urandom) : 5'($urandom_range(7, 0)),
            wv, ($urandom_range(5, 0) == 0), wrd, $urandom);
    end

    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
